// File: rtl/xadc_bcd_converter_pkg.sv
// Shared constants, FSM state type and scaling helper for the XADC BCD path.
// The averaging build is selected with XADC_BCD_AVG_EN.
package xadc_disp_pkg;

  localparam int CODE_W    = 12;
  localparam int BIN_W     = 20;
  localparam int DIGITS    = 7;
  localparam int SAT_CODE  = 4093;
  localparam int SCALE_MUL = 250000;
  localparam int SCALE_SHR = 10;
  localparam int AVG_LOG2  = 4;

  localparam int BCD_W  = 4 * DIGITS;
  localparam int DAB_W  = BCD_W + BIN_W;
  localparam int PROD_W = 30;
  localparam int ACC_W  = CODE_W + AVG_LOG2;
  localparam int AVG_N  = 1 << AVG_LOG2;
  localparam int ITER_W = $clog2(BIN_W);
  localparam int SAT_VAL = 1000000;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    SHIFT
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Code to micro-units of a 1 V full scale, pinned at the top of range.
  function automatic logic [BIN_W-1:0] scale_code(
    input logic [CODE_W-1:0] c
  );
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(SCALE_MUL);
    if (c >= CODE_W'(SAT_CODE))
      return BIN_W'(SAT_VAL);
    return BIN_W'(p >> SCALE_SHR);
  endfunction

endpackage

// File: rtl/xadc_bcd_converter_if.sv
// Code-in / digits-out bundle between the XADC reader and the converter.
// Master drives codes, slave returns status and packed BCD.
interface xadc_bcd_converter_if;
  import xadc_disp_pkg::*;

  logic              code_valid;
  logic [CODE_W-1:0] code_in;
  logic              busy;
  logic              dig_valid;
  logic [BCD_W-1:0]  bcd_out;

  modport master (
    output code_valid,
    output code_in,
    input  busy,
    input  dig_valid,
    input  bcd_out
  );

  modport slave (
    input  code_valid,
    input  code_in,
    output busy,
    output dig_valid,
    output bcd_out
  );

endinterface

// File: rtl/xadc_bcd_converter_bcd_dabble_step.sv
// One double-dabble iteration: add-3 on every digit >= 5, then shift left.
// Purely combinational; the FSM feeds it back once per cycle.
module bcd_dabble_step
  import xadc_disp_pkg::*;
(
  input  logic [DAB_W-1:0] cur,
  output logic [DAB_W-1:0] nxt
);

  logic [DAB_W-1:0] adj;
  bcd_digit_t       d;

  // Correct each BCD digit so the following shift carries decimally.
  always_comb begin
    adj = cur;
    d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = cur[BIN_W + 4*i +: 4];
      if (d >= 4'd5)
        adj[BIN_W + 4*i +: 4] = d + 4'd3;
    end
  end

  assign nxt = {adj[DAB_W-2:0], 1'b0};

endmodule

// File: rtl/xadc_bcd_converter.sv
// XADC code to 7-digit BCD converter: scale, saturate, iterative dabble.
// Define XADC_BCD_AVG_EN to convert the mean of every 16 accepted codes.
module xadc_bcd_converter
  import xadc_disp_pkg::*;
(
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  xadc_bcd_converter_if.slave bus
);

  state_t              state;
  logic                busy_q;
  logic                dig_valid_q;
  logic [BCD_W-1:0]    bcd_q;
  logic [CODE_W-1:0]   code_q;
  logic [DAB_W-1:0]    shadow;
  logic [ITER_W-1:0]   iter;
  logic [DAB_W-1:0]    step_nxt;

`ifdef XADC_BCD_AVG_EN
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] smp;
  logic [ACC_W-1:0]    sum;

  assign sum = acc + ACC_W'(bus.code_in);
`endif

  bcd_dabble_step u_step (
    .cur (shadow),
    .nxt (step_nxt)
  );

  assign bus.busy      = busy_q;
  assign bus.dig_valid = dig_valid_q;
  assign bus.bcd_out   = bcd_q;

  // Capture, scale, then 20 dabble iterations; publish only the final digits.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      dig_valid_q <= 1'b0;
      bcd_q       <= '0;
      code_q      <= '0;
      shadow      <= '0;
      iter        <= '0;
`ifdef XADC_BCD_AVG_EN
      acc         <= '0;
      smp         <= '0;
`endif
    end else begin
      dig_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.code_valid) begin
`ifdef XADC_BCD_AVG_EN
            if (smp == AVG_LOG2'(AVG_N - 1)) begin
              code_q <= sum[ACC_W-1:AVG_LOG2];
              acc    <= '0;
              smp    <= '0;
              busy_q <= 1'b1;
              state  <= SCALE;
            end else begin
              acc <= sum;
              smp <= smp + 1'b1;
            end
`else
            code_q <= bus.code_in;
            busy_q <= 1'b1;
            state  <= SCALE;
`endif
          end
        end
        SCALE: begin
          shadow <= {{BCD_W{1'b0}}, scale_code(code_q)};
          iter   <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          shadow <= step_nxt;
          iter   <= iter + 1'b1;
          if (iter == ITER_W'(BIN_W - 1)) begin
            bcd_q       <= step_nxt[DAB_W-1:BIN_W];
            dig_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_bcd_converter.sv
// Randomised scoreboard bench for xadc_bcd_converter.
// Covers both builds; XADC_BCD_AVG_EN switches the reference model.
module tb_xadc_bcd_converter;
  import xadc_disp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  xadc_bcd_converter_if bus ();

  xadc_bcd_converter dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  typedef struct {
    logic [27:0] bcd;
    int          due;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nconv = 0;
  int last_acc = -100;
  int acc_m = 0;
  int n_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Decimal reading in micro-units, split into digits arithmetically.
  function automatic logic [27:0] ref_bcd(input int code);
    int v;
    logic [27:0] r;
    if (code >= 4093) v = 1000000;
    else v = (code * 250000) / 1024;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Monitor: every dig_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && bus.dig_valid) begin
      exp_t e;
      nconv++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_dig_valid: got bcd %h expected none",
                 bus.bcd_out);
      end else begin
        e = q.pop_front();
        chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
        chk("latency_edge", 32'(cyc - 1), 32'(e.due));
      end
    end
  end

  task automatic start_conv(input int c, input int e);
    last_acc = e;
    q.push_back('{ref_bcd(c), e + 21});
  endtask

  task automatic accept(input int code, input int e);
`ifdef XADC_BCD_AVG_EN
    acc_m += code;
    n_m++;
    if (n_m == 16) begin
      start_conv(acc_m / 16, e);
      acc_m = 0;
      n_m = 0;
    end
`else
    start_conv(code, e);
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from edge timing.
  task automatic step(input bit v, input int code);
    int e;
    @(negedge clk);
    bus.code_valid = v;
    bus.code_in = 12'(code);
    @(posedge clk);
    e = cyc;
    if (v && e >= last_acc + 22) accept(code % 4096, e);
    #1;
    chk("busy", 32'(bus.busy),
        32'((e >= last_acc && e <= last_acc + 20) ? 1 : 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_bcd_out", 32'(bus.bcd_out), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_dig_valid", 32'(bus.dig_valid), 32'h0);
    q.delete();
    last_acc = -100;
    acc_m = 0;
    n_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int dir_code[6] = '{0, 2048, 1, 4092, 4093, 4095};
  logic [27:0] dir_exp[6] = '{28'h0000000, 28'h0500000, 28'h0000244,
                              28'h0999023, 28'h1000000, 28'h1000000};

  initial begin
    int n0;
    bus.code_valid = 1'b0;
    bus.code_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd_out", 32'(bus.bcd_out), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_dig_valid", 32'(bus.dig_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(1'b1, dir_code[i]);
      idle(24);
`ifndef XADC_BCD_AVG_EN
      chk("directed_bcd", 32'(bus.bcd_out), 32'(dir_exp[i]));
`endif
    end

    step(1'b1, 2048);
    idle(11);
    do_reset();
    idle(24);
    step(1'b1, 4092);
    idle(24);
`ifndef XADC_BCD_AVG_EN
    chk("after_reset_bcd", 32'(bus.bcd_out), 32'h0999023);
`endif

    n0 = nconv;
    for (int i = 0; i < 50; i++) step(1'b1, 100 * (i + 1));
    idle(25);
`ifndef XADC_BCD_AVG_EN
    chk("flood_conversions", 32'(nconv - n0), 32'd3);
`endif

`ifdef XADC_BCD_AVG_EN
    do_reset();
    n0 = nconv;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 100 + i);
      if (i < 15) chk("avg_no_busy", 32'(bus.busy), 32'h0);
      step(1'b0, 0);
    end
    idle(25);
    chk("avg_conversions", 32'(nconv - n0), 32'd1);
    chk("avg_bcd", 32'(bus.bcd_out), 32'h0026123);
`endif

    for (int i = 0; i < 40; i++) begin
      step(1'b1, int'($urandom_range(0, 4095)));
      idle(int'($urandom_range(0, 30)));
    end

    for (int i = 0; i < 30 && q.size() != 0; i++) idle(1);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xadc_bcd_converter.md
Name: xadc_bcd_converter

Overview:
- Sequential converter between the XADC DRP readout and the seven-segment digit multiplexer.
- Takes a 12-bit XADC code (do_out[15:4]) and scales it to a 1 V full-scale reading in micro-units: value = code*250000 >> 10.
- Saturates to 1.000000 at the top of range.
- Runs an iterative double-dabble to produce 7 BCD digits (dig0 = least significant) for the display driver.

Parameters:
- CODE_W, 12, XADC code width.
- DIGITS, 7, number of BCD digits produced.
- SAT_CODE, 4093, codes >= this value force the output to 1000000.
- SCALE_MUL, 250000, scale multiplier.
- SCALE_SHR, 10, right shift applied after the multiply.
- BIN_W, 20, width of the scaled binary value (max 1000000 < 2^20).

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- CPU_RESETN  in  1  asynchronous active-low reset.
- code_valid  in  1  single-cycle qualifier for code_in.
- code_in  in  12  unsigned XADC code.
- busy  out  1  high while a conversion is in progress.
- dig_valid  out  1  one-cycle pulse when bcd_out updates.
- bcd_out  out  28  packed BCD digits; [3:0] = dig0 ... [27:24] = dig6.

Behaviour:
- Reset: async assert on CPU_RESETN low. State = IDLE, busy = 0, dig_valid = 0, bcd_out = 0, all internal registers = 0. Deassertion is synchronous to CLK100MHZ.
- FSM states: IDLE, SCALE, SHIFT.
- IDLE:
  - code_valid = 1 at edge k: capture code_in, go to SCALE.
  - busy = (state != IDLE).
- SCALE (edge k+1):
  - If code >= SAT_CODE: bin = 1000000.
  - Else: bin = (code * SCALE_MUL) >> SCALE_SHR, with a 30-bit product truncated to BIN_W.
  - Clear the BCD shadow register and iteration counter; go to SHIFT.
- SHIFT (edges k+2 .. k+21): 20 iterations, one per cycle. For each iteration:
  - Any shadow digit >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - On the 20th iteration (edge k+21): bcd_out loads the final shadow, dig_valid = 1 for exactly one cycle, go to IDLE.
- Latency: acceptance edge to bcd_out update is exactly 21 edges. Minimum spacing between accepted codes is 22 cycles.
- code_valid while busy: sample dropped, no queuing, no error flag.
- bcd_out holds its value between updates. It never shows a partial result.
- Reset mid-conversion: the conversion is abandoned, outputs return to reset values, and no dig_valid is produced.
- All digits are always in the range 0..9. Digit 6 is nonzero only at saturation.

Optional Feature:
- Macro: XADC_BCD_AVG_EN.
- Defined:
  - Each accepted code adds into a 16-bit accumulator; a 4-bit sample counter increments.
  - On the 16th sample: the converted code is acc >> 4, the accumulator and counter clear, and the FSM enters SCALE.
  - Samples 1..15 do not raise busy.
  - code_valid during busy is dropped and not accumulated.
  - Reset clears the accumulator and counter.
- Undefined: every accepted code is converted individually, as described in Behaviour.

Decomposition:
- Package xadc_disp_pkg holds:
  - CODE_W, BIN_W, DIGITS, SAT_CODE, SCALE_MUL, SCALE_SHR, AVG_LOG2 = 4.
  - The FSM state enum type.
  - The BCD digit type (4-bit).
- One sub-module: bcd_dabble_step, combinational.
  - Inputs: current {bcd, bin}. Output: the next value after add-3 correction and one left shift.
  - Instantiated once and iterated by the FSM.

Test Plan:
- code_in = 0 -> after 21 edges, dig_valid pulse, bcd_out = 0x0000000.
- code_in = 2048 -> bcd_out = 0x0500000. Then code_in = 1 -> bcd_out = 0x0000244.
- code_in = 4092 -> 0x0999023. code_in = 4093 and 4095 -> 0x1000000 (saturation boundary).
- code_valid every cycle for 50 cycles with codes 100, 200, ... -> exactly 3 conversions (accepted at cycles 0, 22, 44); bcd_out matches only the accepted codes; busy is high between acceptances.
- CPU_RESETN pulsed low at SHIFT iteration 10 of code 2048 -> bcd_out = 0 and busy = 0 immediately, no dig_valid. The next code 4092 converts correctly.
- With XADC_BCD_AVG_EN: 16 codes 100..115 -> one dig_valid only after the 16th, with average 107 -> bcd_out = 0x0026123. The 15 earlier samples produce no busy assertion.
